// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin N-master to 1-slave memory bus arbiter. Granted
//               master's request is forwarded combinationally to the slave.
//               An in-order FIFO of master indices routes each read response
//               back to the master that issued the read.
// Ports       : clock, reset          - clock, async active-high reset
//               m_*                    - packed per-master request/response
//               s_*                    - single slave request/response
//               outstanding            - reads accepted but not yet answered
//               error                  - sticky: response with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_write_data,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_byte_enable,
    input  logic [NUM_MASTERS-1:0]                m_read_enable,
    input  logic [NUM_MASTERS-1:0]                m_write_enable,
    output logic [NUM_MASTERS-1:0]                m_wait_req,
    output logic [NUM_MASTERS-1:0]                m_valid,
    output logic [DATA_WIDTH-1:0]                 m_read_data,
    output logic [ADDR_WIDTH-1:0]                 s_address,
    output logic [DATA_WIDTH-1:0]                 s_write_data,
    output logic [DATA_WIDTH/8-1:0]               s_byte_enable,
    output logic                                  s_read_enable,
    output logic                                  s_write_enable,
    input  logic                                  s_wait_req,
    input  logic                                  s_valid,
    input  logic [DATA_WIDTH-1:0]                 s_read_data,
    output logic [$clog2(DEPTH+1)-1:0]            outstanding,
    output logic                                  error
);

    localparam int c_IDX_W = $clog2(NUM_MASTERS);
    localparam int c_BE_W  = DATA_WIDTH / 8;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Round-robin start point and routing FIFO state
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_error;

    logic [NUM_MASTERS-1:0] w_eligible;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_grant_found;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic                   w_grant_valid;
    logic                   w_is_write;
    logic                   w_is_read;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_spurious;
    logic [c_IDX_W-1:0]     w_head;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Full comes from registered occupancy only, so a same-cycle response
    // never frees a slot for a read and s_valid never reaches the grant logic.
    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_elig
            assign w_eligible[i] = m_write_enable[i] | (m_read_enable[i] & ~w_full);
        end
    endgenerate

    // First eligible master scanning from r_rr_ptr upward, wrapping around
    always_comb begin
        int j;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_MASTERS) begin
                j = j - NUM_MASTERS;
            end
            if (!w_grant_found && w_eligible[j]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = c_IDX_W'(j);
            end
        end
    end

    assign w_grant_valid = w_grant_found & ~reset;

    // A master raising both enables is served as a write
    assign w_is_write = m_write_enable[w_grant_idx];
    assign w_is_read  = m_read_enable[w_grant_idx] & ~w_is_write;

    assign s_address      = m_address[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_write_data   = m_write_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign s_byte_enable  = m_byte_enable[int'(w_grant_idx)*c_BE_W +: c_BE_W];
    assign s_write_enable = w_grant_valid & w_is_write;
    assign s_read_enable  = w_grant_valid & w_is_read;

    assign w_accept   = w_grant_valid & ~s_wait_req;
    assign w_push     = w_accept & w_is_read;
    assign w_pop      = s_valid & ~w_empty & ~reset;
    assign w_spurious = s_valid & w_empty;
    assign w_head     = r_fifo[r_rd_ptr];

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master_out
            assign m_wait_req[i] = reset | ~(w_grant_valid & (w_grant_idx == c_IDX_W'(i)))
                                 | s_wait_req;
            assign m_valid[i]    = w_pop & (w_head == c_IDX_W'(i));
        end
    endgenerate

    assign m_read_data = s_read_data;
    assign outstanding = r_count;
    assign error       = r_error;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_grant_idx == c_IDX_W'(NUM_MASTERS - 1)) ? '0
                          : w_grant_idx + c_IDX_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_spurious) begin
                r_error <= 1'b1;
            end
        end
    end

    // Routing storage needs no reset: entries are only read while occupied
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Randomized self-checking bench for bus_arbiter with a
//               behavioural round-robin / in-order routing model and a
//               response scoreboard checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N     = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N*AW-1:0]   m_address = '0;
    logic [N*DW-1:0]   m_write_data = '0;
    logic [N*BW-1:0]   m_byte_enable = '0;
    logic [N-1:0]      m_read_enable = '0;
    logic [N-1:0]      m_write_enable = '0;
    logic [N-1:0]      m_wait_req;
    logic [N-1:0]      m_valid;
    logic [DW-1:0]     m_read_data;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_write_data;
    logic [BW-1:0]     s_byte_enable;
    logic              s_read_enable;
    logic              s_write_enable;
    logic              s_wait_req = 1'b0;
    logic              s_valid = 1'b0;
    logic [DW-1:0]     s_read_data = '0;
    logic [CW-1:0]     outstanding;
    logic              error;

    bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .m_address(m_address), .m_write_data(m_write_data),
        .m_byte_enable(m_byte_enable), .m_read_enable(m_read_enable),
        .m_write_enable(m_write_enable), .m_wait_req(m_wait_req),
        .m_valid(m_valid), .m_read_data(m_read_data),
        .s_address(s_address), .s_write_data(s_write_data),
        .s_byte_enable(s_byte_enable), .s_read_enable(s_read_enable),
        .s_write_enable(s_write_enable), .s_wait_req(s_wait_req),
        .s_valid(s_valid), .s_read_data(s_read_data),
        .outstanding(outstanding), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } resp_t;

    // Behavioural model state: each master's held request, the round-robin
    // start point, the queue of masters awaiting read data, sticky error.
    bit          pv [N];
    bit          pre [N];
    bit          pwe [N];
    logic [31:0] pa [N];
    logic [31:0] pd [N];
    logic [3:0]  pb [N];
    int          rq[$];
    resp_t       sb[$];
    int          rr = 0;
    bit          err_reg = 1'b0;

    int  p_req = 60, p_wait = 25, p_valid = 50;
    bit  gen_en = 1'b1, force_valid = 1'b0;
    int  n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            m_address[i*AW +: AW]     = pa[i];
            m_write_data[i*DW +: DW]  = pd[i];
            m_byte_enable[i*BW +: BW] = pb[i];
            m_read_enable[i]          = pv[i] & pre[i];
            m_write_enable[i]         = pv[i] & pwe[i];
        end
    endtask

    task automatic step();
        int          sizeb;
        int          g;
        int          kind;
        bit          found, full, sw, do_valid, err_next;
        logic [31:0] rd;
        logic [N-1:0] exp_wait;
        resp_t       r;
        @(posedge clock);
        #1;
        if (gen_en) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(99) < p_req) begin
                    kind   = $urandom_range(3);
                    pv[i]  = 1'b1;
                    pwe[i] = (kind >= 2);
                    pre[i] = (kind != 2);
                    pa[i]  = $urandom;
                    pd[i]  = $urandom;
                    pb[i]  = 4'($urandom);
                end
            end
        end
        drive_masters();
        sw         = ($urandom_range(99) < p_wait);
        s_wait_req = sw;
        sizeb      = rq.size();
        do_valid   = force_valid || (sizeb > 0 && $urandom_range(99) < p_valid);
        rd         = $urandom;
        s_valid    = do_valid;
        s_read_data = rd;
        err_next   = err_reg;
        if (do_valid) begin
            if (sizeb > 0) begin
                r.idx  = rq.pop_front();
                r.data = rd;
                sb.push_back(r);
            end else begin
                err_next = 1'b1;
            end
        end
        full  = (sizeb == DEPTH);
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (!found && pv[j] && (pwe[j] || (pre[j] && !full))) begin
                found = 1'b1;
                g     = j;
            end
        end
        #3;
        chk("outstanding", 64'(outstanding), 64'(sizeb));
        chk("error", 64'(error), 64'(err_reg));
        exp_wait = '1;
        if (found && !sw) exp_wait[g] = 1'b0;
        chk("m_wait_req", 64'(m_wait_req), 64'(exp_wait));
        chk("s_write_enable", 64'(s_write_enable), 64'(found && pwe[g]));
        chk("s_read_enable", 64'(s_read_enable), 64'(found && !pwe[g] && pre[g]));
        if (found) begin
            chk("s_address", 64'(s_address), 64'(pa[g]));
            chk("s_write_data", 64'(s_write_data), 64'(pd[g]));
            chk("s_byte_enable", 64'(s_byte_enable), 64'(pb[g]));
        end
        if (found && !sw) begin
            if (!pwe[g]) rq.push_back(g);
            pv[g] = 1'b0;
            rr    = (g + 1) % N;
        end
        err_reg = err_next;
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        m_read_enable  = '1;
        m_write_enable = '1;
        s_valid        = 1'b0;
        s_wait_req     = 1'b0;
        rq.delete();
        rr      = 0;
        err_reg = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            #3;
            chk("rst_m_wait_req", 64'(m_wait_req), 64'({N{1'b1}}));
            chk("rst_s_read_enable", 64'(s_read_enable), 64'd0);
            chk("rst_s_write_enable", 64'(s_write_enable), 64'd0);
            chk("rst_outstanding", 64'(outstanding), 64'd0);
            chk("rst_error", 64'(error), 64'd0);
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        drive_masters();
    endtask

    // Response monitor: every cycle either the expected routed response is
    // present or no m_valid bit may be set.
    always @(negedge clock) begin : mon
        resp_t        e;
        logic [N-1:0] oh;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            chk("m_valid", 64'(m_valid), 64'(oh));
            chk("m_read_data", 64'(m_read_data), 64'(e.data));
        end else begin
            chk("m_valid_idle", 64'(m_valid), 64'd0);
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pre[i] = 1'b0; pwe[i] = 1'b0;
            pa[i] = '0;   pd[i] = '0;    pb[i] = '0;
        end
        apply_reset(3);

        // Mixed traffic with slave stalls and random response timing
        repeat (1500) step();

        // Slave withholds responses: FIFO fills, writes must still proceed
        p_valid = 0;
        repeat (40) step();

        // No stalls, immediate responses: full throughput round-robin
        p_valid = 100;
        p_wait  = 0;
        p_req   = 100;
        repeat (300) step();

        // Drain all held requests
        gen_en = 1'b0;
        repeat (12) step();

        // Single read from master 0, then reset while it is outstanding
        pv[0] = 1'b1; pre[0] = 1'b1; pwe[0] = 1'b0;
        pa[0] = 32'h100; pd[0] = '0; pb[0] = 4'hF;
        p_valid = 0;
        step();
        step();
        apply_reset(2);

        // Late response after reset is spurious
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        repeat (4) step();

        @(posedge clock);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised N-master to 1-slave arbiter for the core's memory bus protocol. It lets the instruction fetch port, the data port and further masters (debug, DMA) share one memory bus slave instead of each master owning a private memory bus. Arbitration is round-robin. An in-order response-routing FIFO allows up to DEPTH reads to be outstanding at the slave, and steers each read_data/valid return back to the master that issued the read.

## Interface
- NUM_MASTERS, 2: number of master ports, ≥2
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width; byte_enable width is DATA_WIDTH/8
- DEPTH, 4: maximum outstanding reads, power of two, ≥1

Ports:
- clock  in  1  sole clock; everything samples on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- m_address  in  NUM_MASTERS*ADDR_WIDTH  per-master address, packed, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_write_data  in  NUM_MASTERS*DATA_WIDTH  per-master write data, packed
- m_byte_enable  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte enables, packed
- m_read_enable  in  NUM_MASTERS  read request per master
- m_write_enable  in  NUM_MASTERS  write request per master
- m_wait_req  out  NUM_MASTERS  request not accepted this cycle
- m_valid  out  NUM_MASTERS  read data valid for master i
- m_read_data  out  DATA_WIDTH  read data, shared by all masters; qualified by m_valid
- s_address, s_write_data, s_byte_enable, s_read_enable, s_write_enable  out  matching widths  request to the slave
- s_wait_req  in  1  slave stall
- s_valid, s_read_data  in  1, DATA_WIDTH  slave read response; responses return in order
- outstanding  out  $clog2(DEPTH+1)  reads accepted whose response has not returned
- error  out  1  sticky flag: a response arrived with no outstanding read

## Operation
- **Request acceptance.** A master's request is accepted in a cycle where its enable is high and its m_wait_req is low. A master holds its request stable until accepted.
- **Write priority.** If read_enable and write_enable are both high on one master, it is treated as a write and the read is ignored.
- **Eligibility.** Master i is eligible if m_write_enable[i] is high, or if m_read_enable[i] is high and the FIFO is not full.
- **Grant.** Combinational. The first eligible master in order ptr, ptr+1, … wraps modulo NUM_MASTERS. ptr is a NUM_MASTERS-index register, reset to 0.
- **Slave request.** The granted master's address, data and byte enables drive the s_* outputs. s_read_enable/s_write_enable follow the granted master's effective request. With no grant, both enables are 0; address and data are don't-care.
- **Wait request.** m_wait_req[i] = reset | !grant[i] | s_wait_req.
- **Pointer update.** On an accepted request (grant and !s_wait_req), ptr becomes granted index + 1, mod NUM_MASTERS. Otherwise ptr holds, so a stalled grant stays with the same master while its request and eligibility persist.
- **Read tracking.** An accepted read pushes the granted index into the FIFO.
- **Read response.** s_valid pops the FIFO head idx and drives m_valid[idx]=1 (all other m_valid bits 0). m_read_data = s_read_data, combinational pass-through.
- **FIFO full.** A pop in the same cycle does not make reads eligible. Full is evaluated from registered state; there is no combinational path from s_valid to grant.
- **Spurious response.** s_valid with the FIFO empty sets error; no m_valid is asserted and state does not change.
- **Writes.** Writes never enter the FIFO and produce no response.
- **outstanding** is the FIFO occupancy: push +1, pop −1, push and pop together leave it unchanged.

## Timing
- **Latency.** Zero-cycle combinational paths: master request → s_* request, s_wait_req → m_wait_req, s_valid/s_read_data → m_valid/m_read_data.
- **Read turnaround.** Earliest response is the cycle after acceptance. The arbiter adds no latency to the slave's latency.
- **Throughput.** One request per cycle when the slave does not stall.
- **While reset is high.**
  - ptr=0, FIFO empty, outstanding=0, error=0.
  - m_wait_req all 1, s_read_enable=s_write_enable=0, m_valid all 0.
- **Reset mid-operation.** Reset discards outstanding read routing. A late s_valid after reset is spurious and sets error.
- **Deassertion.** First arbitration happens in the first clock edge after reset deasserts, starting at master 0.

## Test plan
- **Single read.** Master 0 reads 0x100; slave wait_req=0 and returns 0xDEADBEEF one cycle later → m_valid=2'b01 for exactly one cycle, m_read_data=0xDEADBEEF, outstanding goes 0→1→0.
- **Round-robin.** Both masters read continuously, slave never stalls, responses are immediate → grants alternate 0,1,0,1,… starting at 0 after reset; no master is starved.
- **FIFO full.** DEPTH=2, slave never returns valid → two reads accepted, outstanding=2, third read held with m_wait_req=1. A concurrent write from master 1 is still accepted.
- **In-order routing.** Master 1 reads 0x10, then master 0 reads 0x20; slave returns 0x11 then 0x22 → m_valid[1] with 0x11, then m_valid[0] with 0x22.
- **Stall hold.** Master 0 granted while s_wait_req=1 for 3 cycles and master 1 is also requesting → grant stays on 0 for all 4 cycles; ptr moves to 1 only on acceptance.
- **Spurious response and reset.** Reset asserted with 1 read outstanding, then s_valid → outstanding=0, error=1 and stays 1, no m_valid asserted.
